// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Owns the program counter and feeds instruction words to the single-cycle
// Controller. Fetches one word from instruction memory over a req/ack
// handshake, holds it for execution until the datapath reports exec_done,
// then applies the Controller's next-PC selection and fetches again.
//
// Ports
//   clk        : system clock, rising edge
//   rst_n      : asynchronous reset, active-low
//   mem_req    : instruction memory read request (high only in FETCH)
//   mem_addr   : fetch address, always equal to PC
//   mem_ack    : memory accepted request, mem_rdata valid this cycle
//   mem_rdata  : fetched instruction word
//   inst       : latched instruction
//   OP, func   : inst[31:26] and inst[5:0] for the Controller
//   inst_valid : inst/OP/func valid for execution (ISSUE state)
//   exec_done  : datapath finished; PC_s/rs_data sampled this cycle
//   PC_s       : next-PC select (00 seq, 01 JR, 10 branch, 11 jump)
//   rs_data    : jump-register target
//   PC         : current program counter
//   PC_plus4   : PC + 4 (link value)
//   fetch_err  : sticky fault flag (fetch timeout or misaligned target)
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] inst,
    output logic [5:0]  OP,
    output logic [5:0]  func,
    output logic        inst_valid,
    input  logic        exec_done,
    input  logic [1:0]  PC_s,
    input  logic [31:0] rs_data,
    output logic [31:0] PC,
    output logic [31:0] PC_plus4,
    output logic        fetch_err
);

    localparam int              CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   TO_LAST = CW'(TIMEOUT - 1);

    // ST_RESET is the state held while rst_n is low; it guarantees mem_req is
    // dropped the instant reset asserts, and moves to FETCH on the first clock
    // edge after reset is released.
    typedef enum logic [1:0] {
        ST_RESET,
        ST_FETCH,
        ST_ISSUE,
        ST_ERR
    } state_t;

    state_t         state_reg, state_next;
    logic [31:0]    pc_reg, pc_next;
    logic [31:0]    inst_reg, inst_next;
    logic           err_reg, err_next;
    logic [CW-1:0]  cnt_reg, cnt_next;

    logic [31:0]    pc_plus4_w;
    logic [31:0]    br_off;
    logic [31:0]    target_pc;

    // Next-PC candidates. An x/z select falls through to sequential flow.
    always_comb begin
        pc_plus4_w = pc_reg + 32'd4;
        br_off     = {{14{inst_reg[15]}}, inst_reg[15:0], 2'b00};
        target_pc  = pc_plus4_w;
        case (PC_s)
            2'b01:   target_pc = rs_data;
            2'b10:   target_pc = pc_plus4_w + br_off;
            2'b11:   target_pc = {pc_plus4_w[31:28], inst_reg[25:0], 2'b00};
            default: target_pc = pc_plus4_w;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_RESET;
            pc_reg    <= RESET_PC;
            inst_reg  <= 32'h0;
            err_reg   <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            inst_reg  <= inst_next;
            err_reg   <= err_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        inst_next  = inst_reg;
        err_next   = err_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_RESET: begin
                cnt_next   = '0;
                state_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (mem_ack) begin
                    inst_next  = mem_rdata;
                    cnt_next   = '0;
                    state_next = ST_ISSUE;
                end else if (cnt_reg == TO_LAST) begin
                    // TIMEOUT request cycles elapsed with no acknowledge.
                    err_next   = 1'b1;
                    state_next = ST_ERR;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            ST_ISSUE: begin
                if (exec_done) begin
                    if (target_pc[1:0] != 2'b00) begin
                        // Misaligned target (only JR can produce one): keep PC.
                        err_next   = 1'b1;
                        state_next = ST_ERR;
                    end else begin
                        pc_next    = target_pc;
                        state_next = ST_FETCH;
                    end
                end
            end
            default: begin
                state_next = ST_ERR;
            end
        endcase
    end

    assign mem_req    = (state_reg == ST_FETCH);
    assign inst_valid = (state_reg == ST_ISSUE);
    assign mem_addr   = pc_reg;
    assign inst       = inst_reg;
    assign OP         = inst_reg[31:26];
    assign func       = inst_reg[5:0];
    assign PC         = pc_reg;
    assign PC_plus4   = pc_plus4_w;
    assign fetch_err  = err_reg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] inst;
    logic [5:0]  OP;
    logic [5:0]  func;
    logic        inst_valid;
    logic        exec_done;
    logic [1:0]  PC_s;
    logic [31:0] rs_data;
    logic [31:0] PC;
    logic [31:0] PC_plus4;
    logic        fetch_err;

    int total = 0;
    int bad   = 0;

    instr_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .TIMEOUT  (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .inst       (inst),
        .OP         (OP),
        .func       (func),
        .inst_valid (inst_valid),
        .exec_done  (exec_done),
        .PC_s       (PC_s),
        .rs_data    (rs_data),
        .PC         (PC),
        .PC_plus4   (PC_plus4),
        .fetch_err  (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Checks run at the falling edge; inputs are changed right after them.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // In FETCH at 'addr': check request, acknowledge with 'word' (zero wait),
    // then check the word is issued on the next cycle.
    task automatic fetch_ack(input logic [31:0] addr, input logic [31:0] word);
        chk("fetch_req", {31'b0, mem_req}, 32'd1);
        chk("fetch_addr", mem_addr, addr);
        chk("fetch_valid0", {31'b0, inst_valid}, 32'd0);
        mem_ack   = 1'b1;
        mem_rdata = word;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        chk("issue_valid", {31'b0, inst_valid}, 32'd1);
        chk("issue_req0", {31'b0, mem_req}, 32'd0);
        chk("issue_inst", inst, word);
        $display("fetch addr=%h inst=%h", addr, word);
    endtask

    // In ISSUE: present exec_done for one cycle with the given selection.
    task automatic retire(input logic [1:0] sel, input logic [31:0] rs);
        exec_done = 1'b1;
        PC_s      = sel;
        rs_data   = rs;
        tick();
        exec_done = 1'b0;
        PC_s      = 2'b00;
        rs_data   = 32'h0;
        $display("retire sel=%0d rs=%h -> pc=%h err=%0d", sel, rs, PC, fetch_err);
    endtask

    initial begin
        rst_n     = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        exec_done = 1'b0;
        PC_s      = 2'b00;
        rs_data   = 32'h0;

        // ---- Reset state ----
        @(negedge clk);
        @(negedge clk);
        chk("rst_req", {31'b0, mem_req}, 32'd0);
        chk("rst_pc", PC, 32'h0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_err", {31'b0, fetch_err}, 32'd0);
        chk("rst_pc4", PC_plus4, 32'h4);
        rst_n = 1'b1;
        tick();

        // ---- Zero-wait sequential fetch: 0, 4, 8, then 0xC ----
        fetch_ack(32'h0, 32'h2001_0005);
        chk("op0", {26'b0, OP}, 32'h08);
        chk("func0", {26'b0, func}, 32'h05);
        retire(2'b00, 32'h0);
        fetch_ack(32'h4, 32'h0000_0020);
        chk("func1", {26'b0, func}, 32'h20);
        retire(2'b00, 32'h0);
        fetch_ack(32'h8, 32'h8C22_0004);
        chk("op2", {26'b0, OP}, 32'h23);
        retire(2'b00, 32'h0);
        chk("seq_addr_c", mem_addr, 32'hC);
        chk("seq_req_c", {31'b0, mem_req}, 32'd1);

        // exec_done in FETCH is ignored (would otherwise trap on JR to 0x2).
        exec_done = 1'b1;
        PC_s      = 2'b01;
        rs_data   = 32'h2;
        tick();
        exec_done = 1'b0;
        PC_s      = 2'b00;
        rs_data   = 32'h0;
        chk("ign_err", {31'b0, fetch_err}, 32'd0);
        chk("ign_addr", mem_addr, 32'hC);

        // ---- Slow memory: request held with no ack for 5 cycles ----
        for (int i = 0; i < 5; i++) begin
            chk("wait_req", {31'b0, mem_req}, 32'd1);
            chk("wait_addr", mem_addr, 32'hC);
            chk("wait_valid", {31'b0, inst_valid}, 32'd0);
            tick();
        end
        fetch_ack(32'hC, 32'h0000_0008);

        // ---- Branches from PC=0x40 ----
        retire(2'b01, 32'h40);
        fetch_ack(32'h40, 32'h1000_FFFE);
        chk("br_op", {26'b0, OP}, 32'h04);
        chk("br_pc4", PC_plus4, 32'h44);
        retire(2'b10, 32'h0);
        chk("br_back", mem_addr, 32'h3C);
        fetch_ack(32'h3C, 32'h0000_0000);
        retire(2'b01, 32'h40);
        fetch_ack(32'h40, 32'h1000_0003);
        retire(2'b10, 32'h0);
        chk("br_fwd", mem_addr, 32'h50);
        fetch_ack(32'h50, 32'h0000_0000);

        // ---- Jump from PC=0x1000_0010 ----
        retire(2'b01, 32'h1000_0010);
        fetch_ack(32'h1000_0010, 32'h0C00_0100);
        chk("j_op", {26'b0, OP}, 32'h03);
        chk("j_pc4", PC_plus4, 32'h1000_0014);
        chk("j_pc", PC, 32'h1000_0010);
        retire(2'b11, 32'h0);
        chk("j_target", mem_addr, 32'h1000_0400);
        chk("j_req", {31'b0, mem_req}, 32'd1);

        // ---- Reset asserted mid-FETCH ----
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", {31'b0, mem_req}, 32'd0);
        chk("mid_rst_pc", PC, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_addr", mem_addr, 32'h0);

        // ---- PC_plus4 wrap at the top of the address space ----
        fetch_ack(32'h0, 32'h0000_0000);
        retire(2'b01, 32'hFFFF_FFFC);
        chk("wrap_pc4", PC_plus4, 32'h0);
        fetch_ack(32'hFFFF_FFFC, 32'h0000_0000);
        retire(2'b00, 32'h0);
        chk("wrap_next", mem_addr, 32'h0);

        // ---- Misaligned JR target traps ----
        fetch_ack(32'h0, 32'h0000_0008);
        retire(2'b01, 32'h0000_0202);
        chk("mis_err", {31'b0, fetch_err}, 32'd1);
        chk("mis_pc", PC, 32'h0);
        chk("mis_req", {31'b0, mem_req}, 32'd0);
        chk("mis_valid", {31'b0, inst_valid}, 32'd0);
        mem_ack   = 1'b1;
        exec_done = 1'b1;
        PC_s      = 2'b00;
        tick();
        tick();
        mem_ack   = 1'b0;
        exec_done = 1'b0;
        chk("err_sticky", {31'b0, fetch_err}, 32'd1);
        chk("err_pc_frozen", PC, 32'h0);
        chk("err_req", {31'b0, mem_req}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("err_clr", {31'b0, fetch_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ---- Fetch timeout: 16 request cycles with no ack ----
        for (int i = 0; i < 15; i++) begin
            tick();
        end
        chk("to_req_last", {31'b0, mem_req}, 32'd1);
        chk("to_err_pre", {31'b0, fetch_err}, 32'd0);
        tick();
        chk("to_err", {31'b0, fetch_err}, 32'd1);
        chk("to_req", {31'b0, mem_req}, 32'd0);
        $display("timeout fault err=%0d req=%0d", fetch_err, mem_req);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard bound so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
